// File: rtl/aes_rnd_sched.sv
// Round sequencer for the iterative AES-128 datapath: accepts a block, drives load/round strobes
// and the round-key index, then holds the ciphertext for the consumer until it is taken.
module aes_rnd_sched #(
    parameter int unsigned NR = 10,
    parameter int unsigned DW = 128,
    parameter int unsigned CW = 16
) (
    input  logic          CLK,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          key_ready,
    output logic          rf_valid,
    output logic          rf_en_func,
    output logic [DW-1:0] rf_plain,
    output logic [3:0]    key_sel,
    input  logic [DW-1:0] rf_cipher,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic [CW-1:0] blk_cnt
);

    localparam int unsigned RW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [RW-1:0] rnd_cnt;
    logic [RW-1:0] rnd_cnt_nx;
    logic [RW-1:0] key_sel_nx;
    logic [DW-1:0] plain_nx;
    logic [CW-1:0] blk_cnt_nx;

    // The datapath holds its own ciphertext register; we only gate its visibility.
    assign out_data = rf_cipher;

    // Next-state and next-register decode.
    always_comb begin
        state_nx   = state;
        rnd_cnt_nx = rnd_cnt;
        key_sel_nx = key_sel;
        plain_nx   = rf_plain;
        blk_cnt_nx = blk_cnt;
        in_ready   = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = key_ready;
                if (in_valid && key_ready) begin
                    plain_nx   = in_data;
                    key_sel_nx = '0;
                    state_nx   = S_LOAD;
                end
            end
            S_LOAD: begin
                rnd_cnt_nx = RW'(1);
                key_sel_nx = RW'(1);
                state_nx   = S_ROUND;
            end
            S_ROUND: begin
                if (rnd_cnt == RW'(NR - 1)) begin
                    key_sel_nx = RW'(NR);
                    state_nx   = S_FINAL;
                end else begin
                    rnd_cnt_nx = rnd_cnt + RW'(1);
                    key_sel_nx = key_sel + RW'(1);
                end
            end
            S_FINAL: begin
                state_nx = S_DONE;
            end
            S_DONE: begin
                in_ready = key_ready && out_ready;
                if (out_ready) begin
                    blk_cnt_nx = blk_cnt + CW'(1);
                    // Overlap the hand-off with the next accept to keep one block per 12 cycles.
                    if (in_valid && key_ready) begin
                        plain_nx   = in_data;
                        key_sel_nx = '0;
                        state_nx   = S_LOAD;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; strobes are decoded from the next state so they align with it.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rnd_cnt    <= '0;
            key_sel    <= '0;
            rf_plain   <= '0;
            blk_cnt    <= '0;
            rf_valid   <= 1'b0;
            rf_en_func <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            rnd_cnt    <= rnd_cnt_nx;
            key_sel    <= key_sel_nx;
            rf_plain   <= plain_nx;
            blk_cnt    <= blk_cnt_nx;
            rf_valid   <= (state_nx == S_LOAD);
            rf_en_func <= (state_nx == S_ROUND);
            out_valid  <= (state_nx == S_DONE);
            busy       <= (state_nx != S_IDLE);
        end
    end

endmodule
